// File: rtl/fm_wm_seq_pkg.sv
// Shared types and default bounds for the feature x weight index sequencer.
package fm_wm_seq_pkg;

    localparam int unsigned DEF_MAX_ROWS = 6;
    localparam int unsigned DEF_MAX_COLS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fm_wm_wrap_counter.sv
// Runtime-bounded wrap counter: counts 0..bound, wrap flags count == bound.
// wrap is registered; with en low it tracks the bound presented that cycle,
// so a bound loaded alongside a cleared count is reflected on the next cycle.
module fm_wm_wrap_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] bound,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_inc;

    // Next count when advancing without wrapping.
    always_comb begin
        count_inc = count + WIDTH'(1);
    end

    // Count register with clear priority, wrap on terminal value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                count <= '0;
                wrap  <= (bound == '0);
            end else begin
                count <= count_inc;
                wrap  <= (count_inc == bound);
            end
        end else begin
            wrap <= (count == bound);
        end
    end

endmodule

// File: rtl/fm_wm_index_sequencer.sv
// Row-major (row, col) index generator for the FM x WM combination stage.
// Optional macro FM_WM_SEQ_ABORT_EN adds an abort input that cancels a pass
// from RUN without a done pulse.
module fm_wm_index_sequencer
    import fm_wm_seq_pkg::*;
#(
    parameter int unsigned MAX_ROWS = DEF_MAX_ROWS,
    parameter int unsigned MAX_COLS = DEF_MAX_COLS,
    parameter int unsigned ROW_BW   = $clog2(MAX_ROWS),
    parameter int unsigned COL_BW   = $clog2(MAX_COLS),
    parameter int unsigned FLAT_BW  = $clog2(MAX_ROWS * MAX_COLS),
    parameter int unsigned NR_BW    = $clog2(MAX_ROWS + 1),
    parameter int unsigned NC_BW    = $clog2(MAX_COLS + 1)
) (
`ifdef FM_WM_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [NR_BW-1:0]   num_rows,
    input  logic [NC_BW-1:0]   num_cols,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [ROW_BW-1:0]  row_idx,
    output logic [COL_BW-1:0]  col_idx,
    output logic [FLAT_BW-1:0] flat_idx,
    output logic               col_last,
    output logic               mat_last,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      PROD_BW    = NR_BW + NC_BW;
    localparam logic [NR_BW-1:0] MAX_ROWS_V = NR_BW'(MAX_ROWS);
    localparam logic [NC_BW-1:0] MAX_COLS_V = NC_BW'(MAX_COLS);

    seq_state_t         state;
    logic [NR_BW-1:0]   nr_q;
    logic [NC_BW-1:0]   nc_q;
    logic [FLAT_BW-1:0] last_q;

    logic [NR_BW-1:0]   nr_clamp;
    logic [NC_BW-1:0]   nc_clamp;
    logic [NR_BW-1:0]   nr_sel;
    logic [NC_BW-1:0]   nc_sel;
    logic [PROD_BW-1:0] prod;
    logic [FLAT_BW-1:0] last_c;
    logic [ROW_BW-1:0]  row_bound;
    logic [COL_BW-1:0]  col_bound;
    logic               bounds_zero;
    logic               load;
    logic               hs;
    logic               at_end;
    logic               run_keep;
    logic               cnt_clr;
    logic               col_en;
    logic               row_en;
    logic               col_wrap;
    logic               row_wrap;
    logic               abort_i;

`ifdef FM_WM_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Clamp start bounds and precompute the final flat index of the pass.
    always_comb begin
        nr_clamp    = (num_rows > MAX_ROWS_V) ? MAX_ROWS_V : num_rows;
        nc_clamp    = (num_cols > MAX_COLS_V) ? MAX_COLS_V : num_cols;
        bounds_zero = (nr_clamp == '0) || (nc_clamp == '0);
        prod        = PROD_BW'(nr_clamp) * PROD_BW'(nc_clamp);
        last_c      = FLAT_BW'(prod - PROD_BW'(1));
    end

    // Counter control: bounds come straight from the inputs on the start cycle.
    always_comb begin
        hs        = out_valid & out_ready;
        at_end    = col_wrap & row_wrap;
        load      = (state == IDLE) & start & ~bounds_zero;
        run_keep  = (state == RUN) & ~abort_i & ~(hs & at_end);
        cnt_clr   = ~(load | run_keep);
        col_en    = (state == RUN) & hs;
        row_en    = col_en & col_wrap;
        nr_sel    = (state == IDLE) ? nr_clamp : nr_q;
        nc_sel    = (state == IDLE) ? nc_clamp : nc_q;
        row_bound = ROW_BW'(nr_sel - NR_BW'(1));
        col_bound = COL_BW'(nc_sel - NC_BW'(1));
    end

    fm_wm_wrap_counter #(
        .WIDTH (COL_BW)
    ) u_col_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (col_en),
        .bound   (col_bound),
        .count   (col_idx),
        .wrap    (col_wrap)
    );

    fm_wm_wrap_counter #(
        .WIDTH (ROW_BW)
    ) u_row_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (row_en),
        .bound   (row_bound),
        .count   (row_idx),
        .wrap    (row_wrap)
    );

    assign col_last = col_wrap;

    // Pass FSM with registered handshake, status and flat index outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            nr_q      <= '0;
            nc_q      <= '0;
            last_q    <= '0;
            flat_idx  <= '0;
            out_valid <= 1'b0;
            mat_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nr_q     <= nr_clamp;
                        nc_q     <= nc_clamp;
                        last_q   <= last_c;
                        flat_idx <= '0;
                        busy     <= 1'b1;
                        if (bounds_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                            mat_last  <= (last_c == '0);
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        mat_last  <= 1'b0;
                        flat_idx  <= '0;
                    end else if (hs) begin
                        if (at_end) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            mat_last  <= 1'b0;
                            flat_idx  <= '0;
                        end else begin
                            flat_idx <= flat_idx + FLAT_BW'(1);
                            mat_last <= ((flat_idx + FLAT_BW'(1)) == last_q);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    mat_last  <= 1'b0;
                    flat_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_wm_index_sequencer.sv
// Bench for fm_wm_index_sequencer: directed and randomized passes checked
// against an arithmetic row-major model (row = k / nc, col = k % nc).
module tb_fm_wm_index_sequencer;

    localparam int MR = 6;
    localparam int MC = 6;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       start     = 1'b0;
    logic [2:0] num_rows  = '0;
    logic [2:0] num_cols  = '0;
    logic       out_ready = 1'b0;
`ifdef FM_WM_SEQ_ABORT_EN
    logic       abort     = 1'b0;
`endif

    logic       out_valid;
    logic [2:0] row_idx;
    logic [2:0] col_idx;
    logic [5:0] flat_idx;
    logic       col_last;
    logic       mat_last;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fm_wm_index_sequencer dut (
`ifdef FM_WM_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_rows  (num_rows),
        .num_cols  (num_cols),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .row_idx   (row_idx),
        .col_idx   (col_idx),
        .flat_idx  (flat_idx),
        .col_last  (col_last),
        .mat_last  (mat_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All index/status outputs at their quiescent values; busy/done given.
    task automatic chk_quiet(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "/out_valid"}, out_valid, 0);
        chk({tag, "/busy"},      busy,      exp_busy);
        chk({tag, "/done"},      done,      exp_done);
        chk({tag, "/row"},       row_idx,   0);
        chk({tag, "/col"},       col_idx,   0);
        chk({tag, "/flat"},      flat_idx,  0);
        chk({tag, "/col_last"},  col_last,  0);
        chk({tag, "/mat_last"},  mat_last,  0);
    endtask

    // One full pass, entered and left at a falling edge with the DUT idle.
    // mode 0: ready always high, 1: ready toggles, 2: random ready.
    // poke drives stray starts with junk bounds while the pass is active.
    task automatic run_pass(input int nr_in, input int nc_in, input int mode, input bit poke);
        int enr;
        int enc;
        int total;
        int k;
        int cyc;
        enr   = (nr_in > MR) ? MR : nr_in;
        enc   = (nc_in > MC) ? MC : nc_in;
        total = enr * enc;
        chk("pre_start/busy", busy, 0);
        start     = 1'b1;
        num_rows  = 3'(nr_in);
        num_cols  = 3'(nc_in);
        out_ready = (mode == 1) ? 1'b0 : 1'b1;
        @(negedge clk);
        start    = 1'b0;
        num_rows = 3'($urandom);
        num_cols = 3'($urandom);
        k   = 0;
        cyc = 0;
        while (k < total && cyc < 400) begin
            chk("run/out_valid", out_valid, 1);
            chk("run/busy",      busy,      1);
            chk("run/done",      done,      0);
            chk("run/row",       row_idx,   k / enc);
            chk("run/col",       col_idx,   k % enc);
            chk("run/flat",      flat_idx,  k);
            chk("run/col_last",  col_last,  (k % enc) == (enc - 1));
            chk("run/mat_last",  mat_last,  k == (total - 1));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_ready) k++;
            if (poke) begin
                start    = ($urandom_range(0, 2) == 0);
                num_rows = 3'($urandom);
                num_cols = 3'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        chk("run/handshakes", k, total);
        start = poke;
        chk_quiet("done_cycle", 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk_quiet("after_done", 1'b0, 1'b0);
    endtask

    initial begin
        int cyc;

        // Reset state
        repeat (2) @(negedge clk);
        chk_quiet("reset", 1'b0, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset", 1'b0, 1'b0);

        // Directed passes, back to back so each start lands right after done
        run_pass(2, 3, 0, 1'b0);
        run_pass(2, 3, 1, 1'b0);
        run_pass(3, 0, 0, 1'b0);
        run_pass(0, 4, 0, 1'b0);
        run_pass(7, 2, 0, 1'b0);
        run_pass(2, 3, 0, 1'b1);
        run_pass(1, 1, 0, 1'b0);
        run_pass(1, 7, 1, 1'b0);
        run_pass(6, 6, 2, 1'b1);

        // Randomized passes
        for (int i = 0; i < 12; i++) begin
            run_pass(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a pass
        start     = 1'b1;
        num_rows  = 3'd2;
        num_cols  = 3'd3;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (flat_idx != 6'd3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reset/flat_before", flat_idx, 3);
        reset_n = 1'b0;
        #1;
        chk_quiet("mid_reset/async", 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_quiet("mid_reset/idle", 1'b0, 1'b0);
        end

`ifdef FM_WM_SEQ_ABORT_EN
        // Abort during RUN with a concurrent handshake
        start     = 1'b1;
        num_rows  = 3'd3;
        num_cols  = 3'd4;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (flat_idx != 6'd2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort/flat_before", flat_idx, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_quiet("abort/next", 1'b0, 1'b0);
        @(negedge clk);
        chk_quiet("abort/later", 1'b0, 1'b0);
        // Abort outside RUN: zero-bound pass still pulses done
        abort = 1'b1;
        run_pass(0, 3, 0, 1'b0);
        abort = 1'b0;
`endif

        // Normal pass after the disruptions
        run_pass(3, 2, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
